// File: rtl/ram_arbiter_if.sv
// Shared types and the requester/RAM bus for the four-port RAM arbiter.
// The arbiter takes the slave modport; a requester/RAM model takes master.
package ram_arbiter_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface ram_arbiter_if;
  import ram_arbiter_pkg::*;

  logic [3:0]        ren;
  logic [3:0]        wen;
  logic [3:0]        lock;
  logic [3:0][31:0]  addr;
  logic [3:0][31:0]  wdata;
  logic [3:0]        rwait;
  logic [31:0]       rdata;
  logic              err;
  logic              ramREN;
  logic              ramWEN;
  logic [31:0]       ramaddr;
  logic [31:0]       ramstore;
  logic [31:0]       ramload;
  ramstate_t         ramstate;

  modport slave (
    input  ren, wen, lock, addr, wdata, ramload, ramstate,
    output rwait, rdata, err, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output ren, wen, lock, addr, wdata, ramload, ramstate,
    input  rwait, rdata, err, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/ram_arbiter.sv
// Four-requester RAM arbiter: dcache over icache, round-robin within a class,
// starvation promotion for icache, optional one-access lock extension.
//
// state  | meaning
// IDLE   | no grant, strobes low, arbitration happens here
// GRANT  | registered grant drives the RAM until completion/withdraw/error
// LOCKED | same grant held for exactly one more access
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic         CLK,
  input  logic         nRST,
  ram_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [1:0]        grant, grant_nxt;
  logic              ptr_i, ptr_i_nxt;
  logic              ptr_d, ptr_d_nxt;
  logic [1:0][CW-1:0] starve;

  logic [3:0] active;
  logic [1:0] promoted;
  logic [1:0] pick;
  logic       busy;
  logic       active_g;
  logic       complete;
  logic       fault;

  // icache ports cannot write, so only their read strobe makes them active
  assign active = {bus.ren[3:2] | bus.wen[3:2], bus.ren[1:0]};

  always_comb begin
    for (int i = 0; i < 2; i++)
      promoted[i] = active[i] && (starve[i] == CW'(STARVE_LIMIT));
  end

  assign busy     = (state != IDLE);
  assign active_g = active[grant];
  assign complete = busy && active_g && (bus.ramstate == ACCESS);
  assign fault    = busy && active_g && (bus.ramstate == ERROR);

  always_comb begin
    pick = 2'd0;
    if (&promoted)                  pick = {1'b0, ptr_i};
    else if (promoted[0])           pick = 2'd0;
    else if (promoted[1])           pick = 2'd1;
    else if (active[3:2] == 2'b11)  pick = {1'b1, ptr_d};
    else if (active[2])             pick = 2'd2;
    else if (active[3])             pick = 2'd3;
    else if (active[1:0] == 2'b11)  pick = {1'b0, ptr_i};
    else if (active[1])             pick = 2'd1;
    else                            pick = 2'd0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      grant <= 2'd0;
      ptr_i <= 1'b0;
      ptr_d <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr_i <= ptr_i_nxt;
      ptr_d <= ptr_d_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_i_nxt = ptr_i;
    ptr_d_nxt = ptr_d;
    case (state)
      IDLE: begin
        if (|active) begin
          grant_nxt = pick;
          state_nxt = GRANT;
        end
      end
      GRANT, LOCKED: begin
        if (!active_g || fault) begin
          state_nxt = IDLE;
        end else if (complete) begin
          state_nxt = (state == GRANT && bus.lock[grant]) ? LOCKED : IDLE;
          if (grant[1]) ptr_d_nxt = ~grant[0];
          else          ptr_i_nxt = ~grant[0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!active[i] || (complete && grant == 2'(i)))
          starve[i] <= '0;
        else if (!(busy && grant == 2'(i)) && starve[i] != CW'(STARVE_LIMIT))
          starve[i] <= starve[i] + 1'b1;
      end
    end
  end

  // strobes follow the live request so a withdrawal drops them the same cycle
  always_comb begin
    bus.ramWEN   = busy && grant[1] && bus.wen[grant];
    bus.ramREN   = busy && bus.ren[grant] && !bus.ramWEN;
    bus.ramaddr  = bus.addr[grant];
    bus.ramstore = bus.wdata[grant];
    bus.rdata    = bus.ramload;
    bus.err      = fault;
    bus.rwait    = 4'hF;
    if (complete) bus.rwait[grant] = 1'b0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: expected completions are queued when a
// request is raised and popped when an rwait bit goes low.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;

  ram_arbiter_if bus();

  ram_arbiter #(.STARVE_LIMIT(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_idx;
  bit          auto_drop;
  bit          sb_on;
  logic [31:0] ld;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(int idx, logic [31:0] a, logic we, logic [31:0] wd);
    exp_t e;
    e.idx = idx; e.addr = a; e.we = we; e.wd = wd;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t       e;
    logic [3:0] m;
    done_idx = -1;
    check("strobe_excl", bus.ramREN & bus.ramWEN, 0);
    if (bus.rwait != 4'hF) begin
      for (int i = 0; i < 4; i++) if (!bus.rwait[i]) done_idx = i;
      if (sb_on) begin
        if (sb.size() == 0) begin
          check("unexpected_done", bus.rwait, 4'hF);
        end else begin
          e = sb.pop_front();
          m = 4'b0001 << e.idx;
          m = ~m;
          check("done_rwait", bus.rwait, m);
          check("done_addr", bus.ramaddr, e.addr);
          check("done_wen", bus.ramWEN, e.we);
          check("done_ren", bus.ramREN, !e.we);
          if (e.we) check("done_store", bus.ramstore, e.wd);
          else      check("done_rdata", bus.rdata, ld);
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
    if (auto_drop && done_idx >= 0) begin
      bus.ren[done_idx]  = 1'b0;
      bus.wen[done_idx]  = 1'b0;
      bus.lock[done_idx] = 1'b0;
    end
    ld = $urandom;
    bus.ramload = ld;
  endtask

  task automatic run_until_empty(int max);
    int n = 0;
    while (sb.size() > 0 && n < max) begin
      cyc();
      n++;
    end
    check("sb_timeout", sb.size(), 0);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    bus.ren = '0; bus.wen = '0; bus.lock = '0;
    bus.ramstate = FREE;
    sb.delete();
    auto_drop = 1'b0;
    sb_on = 1'b1;
    #1;
    check("rst_rwait", bus.rwait, 4'hF);
    check("rst_ren", bus.ramREN, 0);
    check("rst_wen", bus.ramWEN, 0);
    check("rst_err", bus.err, 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int          n;
    bit          got;
    logic [31:0] d1, d2;
    for (int i = 0; i < 4; i++) begin
      bus.addr[i]  = 32'h1000 + 32'(i * 16);
      bus.wdata[i] = $urandom;
    end
    ld = $urandom;
    bus.ramload = ld;
    #1;

    // dcache 2 beats icache 0; icache write strobe is ignored
    do_reset();
    auto_drop = 1'b1;
    bus.ramstate = ACCESS;
    bus.ren = 4'b0101;
    bus.wen = 4'b0001;
    push(2, bus.addr[2], 1'b0, 32'h0);
    push(0, bus.addr[0], 1'b0, 32'h0);
    run_until_empty(10);

    // two held dcache writers alternate
    do_reset();
    bus.ramstate = ACCESS;
    bus.wen = 4'b1100;
    push(2, bus.addr[2], 1'b1, bus.wdata[2]);
    push(3, bus.addr[3], 1'b1, bus.wdata[3]);
    push(2, bus.addr[2], 1'b1, bus.wdata[2]);
    push(3, bus.addr[3], 1'b1, bus.wdata[3]);
    run_until_empty(20);
    bus.wen = 4'b0000;
    cyc();
    cyc();

    // icache 1 promoted against a hogging dcache 2
    do_reset();
    sb_on = 1'b0;
    bus.ramstate = ACCESS;
    bus.wen = 4'b0100;
    bus.ren = 4'b0010;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      cyc();
      n++;
      if (done_idx == 1) got = 1'b1;
    end
    check("starve_latency_ok", {63'b0, (got && n <= 10)}, 1);
    bus.ren = '0;
    bus.wen = '0;
    cyc();
    sb_on = 1'b1;

    // locked two-word write, then forced release through IDLE
    do_reset();
    bus.ramstate = ACCESS;
    d1 = $urandom;
    d2 = $urandom;
    bus.wen  = 4'b1000;
    bus.lock = 4'b1000;
    bus.addr[3]  = 32'h100;
    bus.wdata[3] = d1;
    push(3, 32'h100, 1'b1, d1);
    push(3, 32'h104, 1'b1, d2);
    cyc();
    cyc();
    bus.addr[3]  = 32'h104;
    bus.wdata[3] = d2;
    cyc();
    check("lock_back_to_back", sb.size(), 0);
    @(negedge CLK);
    check("lock_release_idle", bus.rwait, 4'hF);
    check("lock_idle_wen", bus.ramWEN, 0);
    @(posedge CLK);
    #1;
    bus.wen  = '0;
    bus.lock = '0;
    cyc();
    cyc();
    bus.addr[3] = 32'h1030;

    // withdrawal while BUSY; pointer must stay on dcache 2
    do_reset();
    bus.ramstate = BUSY;
    bus.wen = 4'b0100;
    cyc();
    @(negedge CLK);
    check("wd_grant_wen", bus.ramWEN, 1);
    @(posedge CLK);
    #1;
    bus.wen = 4'b0000;
    @(negedge CLK);
    check("wd_strobe_wen", bus.ramWEN, 0);
    check("wd_strobe_ren", bus.ramREN, 0);
    check("wd_rwait", bus.rwait, 4'hF);
    @(posedge CLK);
    #1;
    bus.wen = 4'b1100;
    bus.ramstate = ACCESS;
    auto_drop = 1'b1;
    push(2, bus.addr[2], 1'b1, bus.wdata[2]);
    push(3, bus.addr[3], 1'b1, bus.wdata[3]);
    @(negedge CLK);
    check("wd_idle_next", bus.rwait, 4'hF);
    @(posedge CLK);
    #1;
    run_until_empty(10);

    // RAM error on grant 2
    do_reset();
    bus.ramstate = ERROR;
    bus.wen = 4'b0100;
    @(negedge CLK);
    check("err_in_idle", bus.err, 0);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("err_pulse", bus.err, 1);
    check("err_rwait", bus.rwait, 4'hF);
    @(posedge CLK);
    #1;
    bus.ramstate = ACCESS;
    bus.wen = 4'b1100;
    auto_drop = 1'b1;
    push(2, bus.addr[2], 1'b1, bus.wdata[2]);
    push(3, bus.addr[3], 1'b1, bus.wdata[3]);
    @(negedge CLK);
    check("err_cleared", bus.err, 0);
    check("err_idle_next", bus.rwait, 4'hF);
    @(posedge CLK);
    #1;
    run_until_empty(10);

    // reset asserted mid-GRANT
    do_reset();
    bus.ramstate = BUSY;
    bus.wen = 4'b1000;
    cyc();
    @(negedge CLK);
    check("mid_grant_wen", bus.ramWEN, 1);
    @(posedge CLK);
    #1;
    bus.ramstate = ACCESS;
    nRST = 1'b0;
    #1;
    check("arst_rwait", bus.rwait, 4'hF);
    check("arst_wen", bus.ramWEN, 0);
    check("arst_ren", bus.ramREN, 0);
    check("arst_err", bus.err, 0);
    @(negedge CLK);
    check("arst_no_pulse", bus.rwait, 4'hF);
    bus.wen = '0;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: cycles an instruction requester may stay pending before it is promoted.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 ren  input  4  read request per requester; index 0/1 = icache 0/1, index 2/3 = dcache 0/1.
REQ-005 wen  input  4  write request per requester; icache bits 0/1 are ignored.
REQ-006 lock  input  4  holds the grant after completion, used for two-word block transfers.
REQ-007 addr  input  4x32  word address per requester.
REQ-008 wdata  input  4x32  store data per requester.
REQ-009 rwait  output  4  wait per requester; 0 for exactly the completing cycle.
REQ-010 rdata  output  32  ramload broadcast to all requesters.
REQ-011 err  output  1  one-cycle pulse when the RAM reports ERROR on the granted access.
REQ-012 ramREN, ramWEN  output  1 each  RAM strobes; never both 1.
REQ-013 ramaddr, ramstore  output  32 each  address and data of the granted requester.
REQ-014 ramload  input  32  RAM read data.
REQ-015 ramstate  input  ramstate_t  FREE/BUSY/ACCESS/ERROR.

Function
REQ-016 FSM states: IDLE, GRANT, LOCKED.
- IDLE: no grant; all RAM strobes 0.
- GRANT: grant index g is registered and RAM strobes reflect g.
- LOCKED: g is held for one further access.
REQ-017 Active requester: (ren|wen)[i] for dcache; ren[i] for icache.
REQ-018 Arbitration occurs in IDLE only; the grant is registered and GRANT is entered the next cycle.
- Arbitration is combinational on the cycle in IDLE.
- With no active requester, stay in IDLE.
REQ-019 Priority order:
- First, a promoted (starving) icache requester.
- Then dcache over icache.
- Within a class, round-robin by a 1-bit pointer per class; the pointer selects the favoured index.
REQ-020 On completion of a grant, the pointer of the granted class is set to the index not granted.
REQ-021 In GRANT/LOCKED:
- ramaddr = addr[g]; ramstore = wdata[g].
- ramWEN = wen[g] (dcache only).
- ramREN = ren[g] & !ramWEN; write wins when both are set.
REQ-022 Completion occurs when ramstate==ACCESS in GRANT/LOCKED.
- rwait[g]=0 that cycle; rdata=ramload.
- Next state: LOCKED if lock[g]=1 and state==GRANT; otherwise IDLE.
- In all other cycles every rwait bit is 1.
REQ-023 LOCKED completes one access, then returns to IDLE regardless of lock; there is no indefinite hold.
REQ-024 Withdrawal: if g's request drops while in GRANT/LOCKED, the arbiter goes to IDLE next cycle with no completion and no pointer update; strobes drop combinationally that cycle.
REQ-025 ramstate==ERROR in GRANT/LOCKED:
- err pulses 1 that cycle; rwait[g] stays 1.
- The arbiter goes to IDLE; the pointer is unchanged.
REQ-026 Starvation counters, one per icache requester:
- Increment each cycle the requester is active and not granted.
- Saturate at STARVE_LIMIT; clear on its completion or when inactive.
- Count == STARVE_LIMIT marks it promoted.
- If both are promoted, the round-robin pointer decides.
REQ-027 Minimum latency from request to completion is 2 cycles (IDLE arbitrate, GRANT with ACCESS), with no back-to-back grants without passing IDLE except via LOCKED.

Reset
REQ-028 On nRST low, asynchronously:
- state=IDLE; grant=0; both pointers=0; starvation counters=0.
- rwait=4'b1111; ramREN=ramWEN=0; err=0.
REQ-029 After release, the first arbitration occurs in the first cycle in IDLE with an active request.
REQ-030 Reset asserted mid-GRANT aborts the access; no rwait low pulse is produced.

Verification
REQ-031 ren=4'b0101, ramstate ACCESS every cycle -> grant 2 completes (rwait=4'b1011 one cycle), then grant 0; icache 0 waits.
REQ-032 wen[2]=wen[3]=1 held, RAM instant -> completions alternate 2,3,2,3; ramWEN=1, ramREN=0 throughout GRANT.
REQ-033 ren[1]=1 with dcache 2 continuously requesting, STARVE_LIMIT=8 -> icache 1 is granted within 8+2 cycles of its request.
REQ-034 lock[3]=1, wen[3]=1, addr 0x100 then 0x104 -> two consecutive completions to requester 3 with no IDLE between, then IDLE.
REQ-035 Granted request withdrawn while ramstate=BUSY -> strobes 0 same cycle, IDLE next cycle, rwait stays 4'b1111, pointer unchanged.
REQ-036 ramstate=ERROR during grant 2 -> err=1 one cycle, rwait[2]=1, IDLE next; nRST low mid-GRANT -> all outputs at reset values immediately.
